logic_gates: RTL and testbench



---
 rtl/logic_gates.sv | 114 +++++++++++
 tb/tb_logic_gates.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates.sv
// logic_gates: registered bitwise gate unit.
// Captures two WIDTH-bit operands when in_valid is high and presents AND, OR,
// NOT, NAND, NOR, XOR and XNOR of them one clock later, with out_valid marking
// the cycle a fresh result appears.
// Optional build macro: LOGIC_GATES_REDUCE_EN adds registered reductions of
// operand A (and_red, or_red, xor_red) under the same capture rule.
module logic_gates #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_gate,
    output logic [WIDTH-1:0] or_gate,
    output logic [WIDTH-1:0] not_gate,
    output logic [WIDTH-1:0] nand_gate,
    output logic [WIDTH-1:0] nor_gate,
    output logic [WIDTH-1:0] xor_gate,
    output logic [WIDTH-1:0] xnor_gate
`ifdef LOGIC_GATES_REDUCE_EN
    ,
    output logic             and_red,
    output logic             or_red,
    output logic             xor_red
`endif
);

    // Combinational gate results, consumed only by the capture registers so
    // no input-to-output path exists.
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;

    logic             r_valid;
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_not;
    logic [WIDTH-1:0] r_nand;
    logic [WIDTH-1:0] r_nor;
    logic [WIDTH-1:0] r_xor;
    logic [WIDTH-1:0] r_xnor;

    assign w_and = a & b;
    assign w_or  = a | b;
    assign w_xor = a ^ b;

    // Validity flag: one pulse per captured pair, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    // Result registers: load all seven gates together on capture, hold
    // otherwise. Reset forces every output to 0, including the inverted ones,
    // so the inverse invariants only apply after the first capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_and  <= '0;
            r_or   <= '0;
            r_not  <= '0;
            r_nand <= '0;
            r_nor  <= '0;
            r_xor  <= '0;
            r_xnor <= '0;
        end else if (in_valid) begin
            r_and  <= w_and;
            r_or   <= w_or;
            r_not  <= ~a;
            r_nand <= ~w_and;
            r_nor  <= ~w_or;
            r_xor  <= w_xor;
            r_xnor <= ~w_xor;
        end
    end

    assign out_valid = r_valid;
    assign and_gate  = r_and;
    assign or_gate   = r_or;
    assign not_gate  = r_not;
    assign nand_gate = r_nand;
    assign nor_gate  = r_nor;
    assign xor_gate  = r_xor;
    assign xnor_gate = r_xnor;

`ifdef LOGIC_GATES_REDUCE_EN
    logic r_and_red;
    logic r_or_red;
    logic r_xor_red;

    // Reductions of operand A, captured and held exactly like the gate results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_and_red <= 1'b0;
            r_or_red  <= 1'b0;
            r_xor_red <= 1'b0;
        end else if (in_valid) begin
            r_and_red <= &a;
            r_or_red  <= |a;
            r_xor_red <= ^a;
        end
    end

    assign and_red = r_and_red;
    assign or_red  = r_or_red;
    assign xor_red = r_xor_red;
`endif

endmodule

// File: tb/tb_logic_gates.sv
// Self-checking bench for logic_gates: a scalar instance (WIDTH=1) and a byte
// instance (WIDTH=8) share clock and reset. Expected values come from a
// truth-table array, hand constants and a per-bit arithmetic reference model.
module tb_logic_gates;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       iv1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       ov1;
    logic       and1, or1, not1, nand1, nor1, xor1, xnor1;

    logic       iv8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       ov8;
    logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;

`ifdef LOGIC_GATES_REDUCE_EN
    logic andr1, orr1, xorr1;
    logic andr8, orr8, xorr8;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what each instance should show after the next edge.
    logic [6:0]  e1 = '0;
    logic        ev1 = 1'b0;
    logic [55:0] e8 = '0;
    logic        ev8 = 1'b0;
    logic [2:0]  er8 = '0;

    always #5 clk = ~clk;

    logic_gates #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
        .out_valid(ov1), .and_gate(and1), .or_gate(or1), .not_gate(not1),
        .nand_gate(nand1), .nor_gate(nor1), .xor_gate(xor1), .xnor_gate(xnor1)
`ifdef LOGIC_GATES_REDUCE_EN
        , .and_red(andr1), .or_red(orr1), .xor_red(xorr1)
`endif
    );

    logic_gates #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
        .out_valid(ov8), .and_gate(and8), .or_gate(or8), .not_gate(not8),
        .nand_gate(nand8), .nor_gate(nor8), .xor_gate(xor8), .xnor_gate(xnor8)
`ifdef LOGIC_GATES_REDUCE_EN
        , .and_red(andr8), .or_red(orr8), .xor_red(xorr8)
`endif
    );

    // Gate results from arithmetic on 0/1 integers, packed as
    // {and, or, not, nand, nor, xor, xnor}, each 8 bits.
    function automatic logic [55:0] gold(input logic [7:0] x, input logic [7:0] y);
        logic [55:0] r;
        int ai, bi, g_and, g_or, g_xor;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ai = x[i] ? 1 : 0;
            bi = y[i] ? 1 : 0;
            g_and = ai * bi;
            g_or  = ai + bi - ai * bi;
            g_xor = (ai + bi) % 2;
            r[48+i] = (g_and == 1);
            r[40+i] = (g_or == 1);
            r[32+i] = (ai == 0);
            r[24+i] = (g_and == 0);
            r[16+i] = (g_or == 0);
            r[8+i]  = (g_xor == 1);
            r[i]    = (g_xor == 0);
        end
        return r;
    endfunction

    function automatic logic [6:0] gold1(input logic x, input logic y);
        logic [55:0] g;
        g = gold({7'd0, x}, {7'd0, y});
        return {g[48], g[40], g[32], g[24], g[16], g[8], g[0]};
    endfunction

    // {and_red, or_red, xor_red} of an operand from counting its ones.
    function automatic logic [2:0] gold_red(input logic [7:0] x);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (x[i] ? 1 : 0);
        return {ones == 8, ones > 0, (ones % 2) == 1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus (called at a falling edge), update the
    // reference, and return at the next falling edge.
    task automatic drive(input logic v1, input logic x1, input logic y1,
                         input logic v8, input logic [7:0] x8, input logic [7:0] y8);
        iv1 = v1; a1 = x1; b1 = y1;
        iv8 = v8; a8 = x8; b8 = y8;
        ev1 = v1;
        ev8 = v8;
        if (v1) e1 = gold1(x1, y1);
        if (v8) begin
            e8  = gold(x8, y8);
            er8 = gold_red(x8);
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_g1"}, 64'({and1, or1, not1, nand1, nor1, xor1, xnor1}), 64'(e1));
        chk({tag, "_v1"}, 64'(ov1), 64'(ev1));
        chk({tag, "_g8"}, 64'({and8, or8, not8, nand8, nor8, xor8, xnor8}), 64'(e8));
        chk({tag, "_v8"}, 64'(ov8), 64'(ev8));
`ifdef LOGIC_GATES_REDUCE_EN
        chk({tag, "_red8"}, 64'({andr8, orr8, xorr8}), 64'(er8));
`endif
    endtask

    typedef struct {
        logic       a;
        logic       b;
        logic [6:0] exp;
    } tt_t;

    initial begin
        tt_t tt[4];
        tt[0] = '{a: 1'b0, b: 1'b0, exp: 7'b0011101};
        tt[1] = '{a: 1'b0, b: 1'b1, exp: 7'b0111010};
        tt[2] = '{a: 1'b1, b: 1'b0, exp: 7'b0101010};
        tt[3] = '{a: 1'b1, b: 1'b1, exp: 7'b1100001};

        // Reset state with operands toggling underneath.
        @(negedge clk);
        iv1 = 1'b1; a1 = 1'b1; iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        iv1 = 1'b0; iv8 = 1'b0;
        rst_n = 1'b1;

        // Scalar truth table, back to back; each result read one cycle later.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, tt[i].a, tt[i].b, 1'b0, 8'h00, 8'h00);
            chk($sformatf("tt%0d", i), 64'({and1, or1, not1, nand1, nor1, xor1, xnor1}), 64'(tt[i].exp));
            chk($sformatf("tt%0d_valid", i), 64'(ov1), 64'd1);
        end

        // Hold: capture (1,0), then change operands with in_valid low.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("hold_cap_and_xor", 64'({and1, xor1}), 64'(2'b01));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("hold_and_xor", 64'({and1, xor1}), 64'(2'b01));
        chk("hold_valid", 64'(ov1), 64'd0);

        // Byte known answer.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C);
        chk("kat8", 64'({and8, or8, not8, nand8, nor8, xor8, xnor8}),
            64'({8'h24, 8'hBD, 8'h5A, 8'hDB, 8'h42, 8'h99, 8'h66}));
        chk("kat8_valid", 64'(ov8), 64'd1);
`ifdef LOGIC_GATES_REDUCE_EN
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
        chk("red_ff", 64'({andr8, orr8, xorr8}), 64'(3'b110));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00);
        chk("red_01", 64'({andr8, orr8, xorr8}), 64'(3'b011));
`endif

        // Asynchronous reset mid-cycle with stale results loaded, then a
        // capture attempt while reset is held that must be discarded.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h5A);
        check_all("preload");
        #2 rst_n = 1'b0;
        #1;
        e1 = '0; ev1 = 1'b0; e8 = '0; ev8 = 1'b0; er8 = '0;
        check_all("async_rst");
        iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1; iv8 = 1'b1; a8 = 8'h81; b8 = 8'h18;
        @(negedge clk);
        check_all("rst_capture_dropped");
        iv1 = 1'b0; iv8 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        // Random regression against the reference model.
        for (int n = 0; n < 1000; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            check_all($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
